// File: rtl/wm8731_clk_gen_if.sv
// WM8731 clock generator bus: enable request in, codec clocks and
// Clk-domain timing strobes out.
//
// Handshake: Enable is a level request, not a pulse. The generator samples
// it on every Clk edge. Raising it starts a frame on the next edge. Dropping
// it only takes effect at the end of the current frame, and Busy stays high
// until that frame has finished. All outputs are registered. Each strobe
// (BclkRise, BclkFall, FrameStart) is a single Clk cycle wide and is to be
// consumed in the Clk domain.
interface wm8731_clk_gen_if #(
  parameter int BITS_PER_FRAME = 64
);
  localparam int IDX_W = ($clog2(BITS_PER_FRAME) > 1) ? $clog2(BITS_PER_FRAME) : 1;

  logic             Enable;
  logic             Mclk;
  logic             Bclk;
  logic             Lrck;
  logic             BclkRise;
  logic             BclkFall;
  logic             FrameStart;
  logic [IDX_W-1:0] BitIdx;
  logic             Busy;
  logic [1:0]       DbgState;

  modport master (
    input  Enable,
    output Mclk, Bclk, Lrck, BclkRise, BclkFall, FrameStart, BitIdx, Busy, DbgState
  );

  modport slave (
    output Enable,
    input  Mclk, Bclk, Lrck, BclkRise, BclkFall, FrameStart, BitIdx, Busy, DbgState
  );
endinterface

// File: rtl/wm8731_clk_gen.sv
// WM8731 clock/timing generator. Mclk is a free-running divided clock.
// Bclk and Lrck are started at a frame boundary and stopped only after a
// whole frame has completed. Strobes let Clk-domain logic track the codec
// clocks without a second clock domain.
module wm8731_clk_gen #(
  parameter int MCLK_HALF      = 2,
  parameter int BCLK_HALF      = 8,
  parameter int BITS_PER_FRAME = 64
) (
  input  logic             Clk,
  input  logic             Rst,
  wm8731_clk_gen_if.master bus
);
  localparam int MW = ($clog2(MCLK_HALF) > 1) ? $clog2(MCLK_HALF) : 1;
  localparam int BW = ($clog2(BCLK_HALF) > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int IW = ($clog2(BITS_PER_FRAME) > 1) ? $clog2(BITS_PER_FRAME) : 1;

  localparam logic [MW-1:0] MCLK_TC  = MW'(MCLK_HALF - 1);
  localparam logic [BW-1:0] BCLK_TC  = BW'(BCLK_HALF - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(BITS_PER_FRAME - 1);
  localparam logic [IW-1:0] IDX_HALF = IW'(BITS_PER_FRAME / 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [MW-1:0] mclk_cnt;
  logic [BW-1:0] bclk_cnt;
  logic          bclk_tc;
  logic          fall_evt;
  logic          wrap_evt;
  logic          start_evt;
  logic          frame_evt;
  logic [IW-1:0] idx_next;

  assign bus.DbgState = state;

  // Next-state decode. A frame boundary restarts framing unless the
  // generator is draining with Enable still low, in which case it stops.
  always_comb begin
    state_next = state;
    start_evt  = 1'b0;
    frame_evt  = 1'b0;
    bclk_tc    = (bclk_cnt == BCLK_TC);
    fall_evt   = (state != IDLE) && bclk_tc && bus.Bclk;
    wrap_evt   = fall_evt && (bus.BitIdx == IDX_LAST);
    idx_next   = wrap_evt ? '0 : bus.BitIdx + IW'(1);
    case (state)
      IDLE: begin
        if (bus.Enable) begin
          state_next = RUN;
          start_evt  = 1'b1;
        end
      end
      RUN: begin
        frame_evt = wrap_evt;
        if (!bus.Enable) state_next = DRAIN;
      end
      DRAIN: begin
        if (bus.Enable) begin
          state_next = RUN;
          frame_evt  = wrap_evt;
        end else if (wrap_evt) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus the registered Busy flag.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= IDLE;
      bus.Busy <= 1'b0;
    end else begin
      state    <= state_next;
      bus.Busy <= (state_next != IDLE);
    end
  end

  // Mclk divider, free-running in every state.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mclk_cnt <= '0;
      bus.Mclk <= 1'b0;
    end else if (mclk_cnt == MCLK_TC) begin
      mclk_cnt <= '0;
      bus.Mclk <= ~bus.Mclk;
    end else begin
      mclk_cnt <= mclk_cnt + MW'(1);
    end
  end

  // Bclk divider, bit index, Lrck and strobes. Everything is held at zero
  // in IDLE. The stop edge falls out of the normal wrap path with
  // FrameStart suppressed.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      bclk_cnt       <= '0;
      bus.Bclk       <= 1'b0;
      bus.Lrck       <= 1'b0;
      bus.BitIdx     <= '0;
      bus.BclkRise   <= 1'b0;
      bus.BclkFall   <= 1'b0;
      bus.FrameStart <= 1'b0;
    end else begin
      bus.BclkRise   <= 1'b0;
      bus.BclkFall   <= 1'b0;
      if (state == IDLE) begin
        bclk_cnt       <= '0;
        bus.Bclk       <= 1'b0;
        bus.Lrck       <= 1'b0;
        bus.BitIdx     <= '0;
        bus.FrameStart <= start_evt;
      end else begin
        if (bclk_tc) begin
          bclk_cnt     <= '0;
          bus.Bclk     <= ~bus.Bclk;
          bus.BclkRise <= ~bus.Bclk;
          bus.BclkFall <= bus.Bclk;
        end else begin
          bclk_cnt <= bclk_cnt + BW'(1);
        end
        if (fall_evt) begin
          bus.BitIdx <= idx_next;
          bus.Lrck   <= (idx_next >= IDX_HALF);
        end
        bus.FrameStart <= frame_evt;
      end
    end
  end
endmodule

// File: tb/tb_wm8731_clk_gen.sv
// Bench for wm8731_clk_gen: a default-parameter instance driven through
// directed start/stop/re-enable steps, and a small-parameter instance with
// random Enable toggling. Both are checked every cycle against a timing
// model derived from elapsed cycles since frame start.
module tb_wm8731_clk_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_a = 1'b0;
  logic en_b = 1'b0;

  wm8731_clk_gen_if #(.BITS_PER_FRAME(64)) if_a ();
  wm8731_clk_gen_if #(.BITS_PER_FRAME(4))  if_b ();

  assign if_a.Enable = en_a;
  assign if_b.Enable = en_b;

  wm8731_clk_gen #(.MCLK_HALF(2), .BCLK_HALF(8), .BITS_PER_FRAME(64)) dut_a (
    .Clk (clk),
    .Rst (rst),
    .bus (if_a)
  );

  wm8731_clk_gen #(.MCLK_HALF(1), .BCLK_HALF(2), .BITS_PER_FRAME(4)) dut_b (
    .Clk (clk),
    .Rst (rst),
    .bus (if_b)
  );

  // clock / reset
  always #10 clk = ~clk;

  typedef struct packed {
    logic       mclk;
    logic       bclk;
    logic       lrck;
    logic       rise;
    logic       fall;
    logic       fs;
    logic       busy;
    logic [7:0] idx;
  } obs_t;

  obs_t obs_a, obs_b;
  assign obs_a = {if_a.Mclk, if_a.Bclk, if_a.Lrck, if_a.BclkRise, if_a.BclkFall,
                  if_a.FrameStart, if_a.Busy, 8'(if_a.BitIdx)};
  assign obs_b = {if_b.Mclk, if_b.Bclk, if_b.Lrck, if_b.BclkRise, if_b.BclkFall,
                  if_b.FrameStart, if_b.Busy, 8'(if_b.BitIdx)};

  int vectors = 0;
  int miscompares = 0;

  // reference model: parameters per instance, elapsed-time bookkeeping
  int mh[2]  = '{2, 1};
  int bh[2]  = '{8, 2};
  int bpf[2] = '{64, 4};
  int n[2]   = '{0, 0};
  int t[2]   = '{0, 0};
  bit act[2]     = '{1'b0, 1'b0};
  bit last_en[2] = '{1'b0, 1'b0};
  obs_t prev[2];
  int fall_cnt_a = 0;

  // scoreboard: expected values queued by the model, popped at the check
  logic [14:0] exp_q[$];

  function automatic int model_idx(int d);
    if (!act[d]) return -1;
    return (t[d] / (2 * bh[d])) % bpf[d];
  endfunction

  // Advance the model by one Clk edge with the Enable level seen on that edge.
  task automatic model_step(input int d, input bit en);
    obs_t e;
    int   per;
    int   frame;
    bit   live;
    e     = '0;
    per   = 2 * bh[d];
    frame = per * bpf[d];
    n[d]++;
    e.mclk = ((n[d] / mh[d]) % 2) == 1;
    live = 1'b0;
    if (!act[d]) begin
      if (en) begin
        act[d] = 1'b1;
        t[d]   = 0;
        live   = 1'b1;
      end
    end else begin
      t[d]++;
      if ((t[d] % frame) == 0 && !last_en[d] && !en) begin
        act[d] = 1'b0;
        e.fall = 1'b1;
      end else begin
        live = 1'b1;
      end
    end
    if (live) begin
      e.bclk = ((t[d] / bh[d]) % 2) == 1;
      e.idx  = 8'(model_idx(d));
      e.lrck = model_idx(d) >= bpf[d] / 2;
      e.rise = (t[d] % per) == bh[d];
      e.fall = (t[d] > 0) && ((t[d] % per) == 0);
      e.fs   = (t[d] % frame) == 0;
      e.busy = 1'b1;
    end
    last_en[d] = en;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      n[d] = 0; t[d] = 0; act[d] = 1'b0; last_en[d] = 1'b0; prev[d] = '0;
    end
    fall_cnt_a = 0;
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic check_obs(input string tag, input obs_t got);
    obs_t exp;
    exp = exp_q.pop_front();
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s at %0t: got %h (mclk bclk lrck rise fall fs busy idx) expected %h",
             tag, $time, got, exp);
    end
  endtask

  // Strobes must mark Bclk transitions, Lrck moves only with a fall, and
  // no strobe lasts two cycles.
  function automatic bit consistent(obs_t c, obs_t p);
    return (c.rise == (c.bclk && !p.bclk)) && (c.fall == (!c.bclk && p.bclk)) &&
           (c.lrck == p.lrck || c.fall) && !(c.rise && c.fall) &&
           !(c.rise && p.rise) && !(c.fall && p.fall) && !(c.fs && p.fs);
  endfunction

  // driver: one Clk edge, model update, then check just after the edge
  task automatic tick();
    @(posedge clk);
    model_step(0, en_a);
    model_step(1, en_b);
    #1;
    check_obs("dut_a", obs_a);
    check_obs("dut_b", obs_b);
    check_bit("dut_a_strobes", consistent(obs_a, prev[0]), 1'b1);
    check_bit("dut_b_strobes", consistent(obs_b, prev[1]), 1'b1);
    prev[0] = obs_a;
    prev[1] = obs_b;
    if (obs_a.fs) fall_cnt_a = 0;
    else if (obs_a.fall) fall_cnt_a++;
    if ($urandom_range(0, 99) < 3) en_b = ~en_b;
  endtask

  task automatic run_until_idx_a(input int idx);
    for (int i = 0; i < 3000 && model_idx(0) != idx; i++) tick();
    check_int("reach_idx_a", model_idx(0), idx);
  endtask

  initial begin
    // reset state, before any Clk edge
    #1;
    check_obs_zero();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Mclk alone, Enable low
    repeat (20) tick();

    // start and hold for two full frames
    en_a = 1'b1;
    repeat (2100) tick();

    // stop mid-frame, expect the frame to complete
    run_until_idx_a(10);
    en_a = 1'b0;
    for (int i = 0; i < 2000 && if_a.Busy === 1'b1; i++) tick();
    check_bit("stop_busy", if_a.Busy, 1'b0);
    check_int("stop_frame_falls", fall_cnt_a, 64);
    repeat (30) tick();

    // restart, drop at 10, re-raise at 40: no interruption
    en_a = 1'b1;
    run_until_idx_a(10);
    en_a = 1'b0;
    run_until_idx_a(40);
    en_a = 1'b1;
    repeat (2100) tick();

    // random Enable on both instances
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 199) == 0) en_a = ~en_a;
    end

    // asynchronous reset mid-run, no Clk edge before the check
    en_a = 1'b1;
    repeat (700) tick();
    #2;
    rst = 1'b1;
    #1;
    check_obs_zero();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (200) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  task automatic check_obs_zero();
    exp_q.push_back('0);
    exp_q.push_back('0);
    check_obs("reset_a", obs_a);
    check_obs("reset_b", obs_b);
  endtask
endmodule

// File: doc/wm8731_clk_gen.md
Name: wm8731_clk_gen

Overview:
Synthesizable clock/timing generator driven by the 50 MHz system clock Clk. Produces the WM8731 master clock (Mclk), the digital-audio bit clock (Bclk) and the left/right frame clock (Lrck), plus single-cycle Clk-domain strobes. Downstream serializer/deserializer logic runs on Clk and uses these strobes, so it needs no second clock domain. Bclk and Lrck are started and stopped cleanly at frame boundaries under Enable control.

Parameters:
MCLK_HALF, 2, Clk cycles per Mclk half-period (default Mclk = 12.5 MHz); legal range ≥1
BCLK_HALF, 8, Clk cycles per Bclk half-period (default Bclk = 3.125 MHz); legal range ≥2
BITS_PER_FRAME, 64, Bclk periods per Lrck frame (default Lrck ≈ 48.8 kHz); must be even and ≥2

Ports:
Clk  input  1  system clock, 50 MHz, all logic on rising edge
Rst  input  1  asynchronous, active-high reset
Enable  input  1  level request to run Bclk/Lrck
Mclk  output  1  codec master clock, free-running after reset
Bclk  output  1  codec bit clock
Lrck  output  1  frame clock: 0 = left half, 1 = right half
BclkRise  output  1  high in the first Clk cycle in which Bclk = 1
BclkFall  output  1  high in the first Clk cycle in which Bclk = 0 after a falling edge
FrameStart  output  1  high for one Clk cycle at each frame start
BitIdx  output  clog2(BITS_PER_FRAME)  current bit position in the frame
Busy  output  1  high when state ≠ IDLE

Behaviour:
- Reset (asynchronous, takes effect with no Clk edge): all outputs 0, all counters 0, state IDLE.
- All outputs are registered. There is no combinational path from any input to any output.
- Mclk: mclk_cnt counts 0..MCLK_HALF-1. At terminal count, mclk_cnt wraps and Mclk toggles. Runs in every state, is independent of Enable, and starts at the first Clk edge after Rst is released.
- State machine has three states: IDLE, RUN, DRAIN.
- IDLE → RUN when Enable = 1 is sampled.
  - On that edge: bclk_cnt = 0, BitIdx = 0, Bclk = 0, Lrck = 0, FrameStart = 1 for one cycle.
- RUN → DRAIN when Enable = 0 is sampled.
- DRAIN → RUN when Enable = 1 is sampled. No gap and no extra FrameStart; timing continues unchanged.
- DRAIN → IDLE on the Bclk falling edge where BitIdx would wrap from BITS_PER_FRAME-1 to 0.
  - On that edge: Bclk = 0, Lrck = 0, BitIdx = 0, BclkFall = 1, FrameStart = 0.
- Bclk in RUN/DRAIN: bclk_cnt counts 0..BCLK_HALF-1. At terminal count, bclk_cnt wraps and Bclk toggles.
  - First Bclk rise occurs BCLK_HALF cycles after the RUN-entry edge.
  - BclkRise and BclkFall are asserted on the same edge as the corresponding Bclk transition.
- On each Bclk falling edge, BitIdx increments modulo BITS_PER_FRAME.
  - Lrck = (new BitIdx ≥ BITS_PER_FRAME/2). Lrck changes only on Bclk falling edges.
  - When BitIdx wraps to 0 in RUN: FrameStart = 1 on that edge.
- Enable changes within a frame never truncate a frame. Bclk always completes full frames.
- In IDLE: Bclk, Lrck, BitIdx and strobes stay 0; bclk_cnt is held at 0.
- Strobes are exactly one Clk cycle wide. BclkRise and BclkFall are never high in the same cycle.
- Counter widths are clog2 of the respective terminal count, minimum 1 bit. No counter overflows for legal parameters.
- Default timing: Bclk period 16 Clk cycles; frame 1024 Clk cycles; Lrck high for the last 512 cycles of each frame.

Test Plan:
- Reset and Mclk: assert Rst mid-run, no Clk edge → all outputs 0 immediately. Release with Enable = 0 → Mclk toggles every 2 Clk cycles (period 4), Bclk stays 0, Busy = 0.
- Start and steady state: raise Enable and hold.
  - FrameStart at edge E; Busy = 1.
  - First BclkRise at E+8 and first BclkFall at E+16; Bclk period 16.
  - Lrck rises at E+512 (BitIdx = 32). Next FrameStart at E+1024 with Lrck falling; FrameStart period 1024.
- Stop mid-frame: drop Enable while BitIdx = 10.
  - Bclk keeps running until the falling edge at E+1024, then IDLE with Busy = 0 and Bclk = 0.
  - No FrameStart at that edge; 64 BclkFall pulses total in the frame.
- Re-enable in DRAIN: drop Enable at BitIdx = 10, raise it at BitIdx = 40 → no interruption; FrameStart at E+1024 and E+2048; Busy stays 1.
- Strobe/level consistency check (all runs): BclkRise ⇔ Bclk 0→1, BclkFall ⇔ Bclk 1→0, Lrck only changes on a BclkFall cycle, and every strobe is 1 cycle wide.
- Small parameters (MCLK_HALF = 1, BCLK_HALF = 2, BITS_PER_FRAME = 4):
  - Mclk period 2, Bclk period 4, frame 16 cycles.
  - Lrck high for BitIdx 2..3.
  - FrameStart every 16 cycles.
